// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// The types are sized for the default configuration.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bundle of the register file.
// master = pipeline side, slave = register file.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2
) ();

  localparam int unsigned AW = $clog2(NREGS);

  logic [NRD-1:0][AW-1:0]   rd_addr;
  logic [NRD-1:0][XLEN-1:0] rd_data;
  logic [NRD-1:0]           rd_busy;

  logic [NWR-1:0]           wr_en;
  logic [NWR-1:0][AW-1:0]   wr_addr;
  logic [NWR-1:0][XLEN-1:0] wr_data;

  logic                     alloc_en;
  logic [AW-1:0]            alloc_addr;
  logic [NREGS-1:0]         busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
    output rd_data, rd_busy, busy_vec
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write bitmap: alloc sets a bit, a resolving write clears it.
// A same-cycle alloc beats the clear because the new producer supersedes.
module regfile_scoreboard #(
  parameter int unsigned NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alloc_en,
  input  logic [$clog2(NREGS)-1:0] alloc_addr,
  input  logic [NREGS-1:0]         clr_vec,
  output logic [NREGS-1:0]         busy_vec
);

  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] pend_d;

  always_comb begin
    set_vec = '0;
    if (alloc_en && (alloc_addr != '0)) begin
      set_vec[alloc_addr] = 1'b1;
    end
    pend_d    = (busy_vec & ~clr_vec) | set_vec;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= pend_d;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write bypass and a
// pending-producer scoreboard; x0 reads as zero and is never busy.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_mp_if.slave   bus
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs   [NREGS];
  logic [XLEN-1:0]  wr_val [NREGS];
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] pend;

  // Per-register winning write; later (higher-index) ports override earlier ones.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      wr_val[i] = '0;
    end
    for (int p = 0; p < int'(NWR); p++) begin
      if (rst_n && bus.wr_en[p] && (bus.wr_addr[p] != '0)) begin
        wr_hit[bus.wr_addr[p]] = 1'b1;
        wr_val[bus.wr_addr[p]] = bus.wr_data[p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (wr_hit[i]) begin
          regs[i] <= wr_val[i];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_en   (bus.alloc_en),
    .alloc_addr (bus.alloc_addr),
    .clr_vec    (wr_hit),
    .busy_vec   (pend)
  );

  assign bus.busy_vec = pend;

  // A write landing this cycle both bypasses its data and resolves the hazard.
  for (genvar r = 0; r < int'(NRD); r++) begin : g_rd
    logic [AW-1:0] a;
    assign a              = bus.rd_addr[r];
    assign bus.rd_data[r] = wr_hit[a] ? wr_val[a] : regs[a];
    assign bus.rd_busy[r] = pend[a] & ~wr_hit[a];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp in the wide configuration: directed
// hazard/bypass vectors followed by random traffic against a behavioural model.
module tb_regfile_mp;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREGS = 64;
  localparam int unsigned NRD   = 4;
  localparam int unsigned NWR   = 3;
  localparam int unsigned AW    = 6;
  localparam int          NCYC  = 10000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    int          kind;   // 0 rd_data, 1 rd_busy, 2 busy_vec
    int          port;
    logic [63:0] exp;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  logic [63:0] mregs [NREGS];
  logic [63:0] mpend;

  // Monitor: outputs are stable mid-cycle, so drain everything queued for this cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] act;
    while (expq.size() > 0) begin
      e = expq.pop_front();
      case (e.kind)
        0:       act = bus.rd_data[e.port];
        1:       act = 64'(bus.rd_busy[e.port]);
        default: act = bus.busy_vec;
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s port%0d kind%0d: got %h expected %h", e.name, e.port, e.kind, act, e.exp);
      end
    end
  end

  task automatic push(input string n, input int k, input int p, input logic [63:0] v);
    exp_t e;
    e.name = n; e.kind = k; e.port = p; e.exp = v;
    expq.push_back(e);
  endtask

  task automatic exp_rd(input string n, input int p, input logic [63:0] d, input logic b);
    push(n, 0, p, d);
    push(n, 1, p, 64'(b));
  endtask

  task automatic exp_bv(input string n, input logic [63:0] v);
    push(n, 2, 0, v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en      = '0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.alloc_en   = 1'b0;
    bus.alloc_addr = '0;
  endtask

  task automatic set_wr(input int p, input int a, input logic [63:0] d);
    bus.wr_en[p]   = 1'b1;
    bus.wr_addr[p] = AW'(a);
    bus.wr_data[p] = d;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
    bus.rd_addr[0] = AW'(a0);
    bus.rd_addr[1] = AW'(a1);
    bus.rd_addr[2] = AW'(a2);
    bus.rd_addr[3] = AW'(a3);
  endtask

  task automatic alloc(input int a);
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = AW'(a);
  endtask

  function automatic int rnd_addr();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 63));
    return int'($urandom_range(0, 3)) + 7;
  endfunction

  localparam logic [63:0] B9 = 64'h200;

  initial begin
    rst_n = 1'b0;
    idle();
    set_rd(0, 0, 0, 0);

    // Reset: writes/allocs ignored, everything reads zero.
    step();
    set_rd(1, 5, 3, 31);
    set_wr(0, 5, 64'hDEADBEEF);
    alloc(3);
    for (int r = 0; r < 4; r++) exp_rd("rst_read", r, 64'h0, 1'b0);
    exp_bv("rst_bv", 64'h0);
    step();
    idle();
    set_rd(5, 3, 63, 1);
    for (int r = 0; r < 4; r++) exp_rd("rst_hold", r, 64'h0, 1'b0);
    exp_bv("rst_hold_bv", 64'h0);

    // Release; write x5 with bypass, x0 write dropped.
    step();
    rst_n = 1'b1;
    idle();
    set_wr(0, 5, 64'hDEADBEEF);
    set_wr(1, 0, 64'h1234);
    set_rd(5, 0, 3, 2);
    exp_rd("bypass_x5", 0, 64'hDEADBEEF, 1'b0);
    exp_rd("x0_write", 1, 64'h0, 1'b0);
    exp_rd("rst_alloc_gone", 2, 64'h0, 1'b0);
    exp_bv("bv_after_rst", 64'h0);
    step();
    idle();
    set_rd(5, 0, 3, 7);
    exp_rd("stored_x5", 0, 64'hDEADBEEF, 1'b0);
    exp_rd("x0_stored", 1, 64'h0, 1'b0);

    // Write-write conflicts.
    step();
    set_wr(0, 7, 64'h11);
    set_wr(1, 7, 64'h22);
    set_rd(7, 5, 0, 0);
    exp_rd("conflict2_byp", 0, 64'h22, 1'b0);
    exp_rd("x5_unaffected", 1, 64'hDEADBEEF, 1'b0);
    step();
    idle();
    exp_rd("conflict2_st", 0, 64'h22, 1'b0);
    step();
    set_wr(0, 8, 64'hA);
    set_wr(1, 8, 64'hB);
    set_wr(2, 8, 64'hC);
    set_rd(8, 8, 7, 0);
    exp_rd("conflict3_byp0", 0, 64'hC, 1'b0);
    exp_rd("conflict3_byp1", 1, 64'hC, 1'b0);
    exp_rd("x7_keep", 2, 64'h22, 1'b0);
    step();
    idle();
    exp_rd("conflict3_st", 0, 64'hC, 1'b0);

    // Scoreboard: alloc visible next cycle, write clears.
    step();
    alloc(9);
    set_rd(9, 0, 0, 0);
    exp_rd("alloc_same", 0, 64'h0, 1'b0);
    exp_bv("alloc_same_bv", 64'h0);
    step();
    idle();
    exp_rd("alloc_next", 0, 64'h0, 1'b1);
    exp_bv("alloc_next_bv", B9);
    step();
    set_wr(1, 9, 64'h55);
    exp_rd("wr_resolves", 0, 64'h55, 1'b0);
    exp_bv("wr_bv_pre", B9);
    step();
    idle();
    exp_rd("wr_after", 0, 64'h55, 1'b0);
    exp_bv("wr_bv_post", 64'h0);

    // Simultaneous alloc and write: alloc wins after the edge.
    step();
    alloc(9);
    set_wr(0, 9, 64'h66);
    exp_rd("allocwr_same", 0, 64'h66, 1'b0);
    exp_bv("allocwr_same_bv", 64'h0);
    step();
    idle();
    exp_rd("allocwr_next", 0, 64'h66, 1'b1);
    exp_bv("allocwr_bv", B9);
    step();
    alloc(9);
    exp_rd("realloc", 0, 64'h66, 1'b1);
    step();
    idle();
    alloc(0);
    set_wr(2, 0, 64'h77);
    set_rd(9, 0, 0, 0);
    exp_rd("still_pend", 0, 64'h66, 1'b1);
    exp_rd("x0_alloc", 1, 64'h0, 1'b0);
    exp_bv("realloc_bv", B9);
    step();
    idle();
    exp_rd("x0_alloc_next", 1, 64'h0, 1'b0);
    exp_bv("x0_alloc_bv", B9);

    // Asynchronous reset mid-run: checked before any clock edge occurs.
    step();
    rst_n = 1'b0;
    set_rd(5, 7, 9, 8);
    for (int r = 0; r < 4; r++) exp_rd("async_rst", r, 64'h0, 1'b0);
    exp_bv("async_rst_bv", 64'h0);
    step();
    step();
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < int'(NREGS); i++) mregs[i] = '0;
    mpend = '0;
    for (int c = 0; c < NCYC; c++) begin
      logic [63:0] d;
      logic        hit;
      step();
      idle();
      for (int p = 0; p < int'(NWR); p++) begin
        if ($urandom_range(0, 1) == 1) set_wr(p, rnd_addr(), {$urandom, $urandom});
      end
      if ($urandom_range(0, 2) == 0) alloc(rnd_addr());
      for (int r = 0; r < int'(NRD); r++) bus.rd_addr[r] = AW'(rnd_addr());

      for (int r = 0; r < int'(NRD); r++) begin
        int a;
        a   = int'(bus.rd_addr[r]);
        hit = 1'b0;
        d   = mregs[a];
        for (int p = 0; p < int'(NWR); p++) begin
          if (bus.wr_en[p] && int'(bus.wr_addr[p]) == a) begin
            hit = 1'b1;
            d   = bus.wr_data[p];
          end
        end
        if (a == 0) begin
          exp_rd("rnd", r, 64'h0, 1'b0);
        end else begin
          exp_rd("rnd", r, d, mpend[a] & ~hit);
        end
      end
      exp_bv("rnd_bv", mpend);

      for (int p = 0; p < int'(NWR); p++) begin
        if (bus.wr_en[p] && bus.wr_addr[p] != '0) begin
          mregs[bus.wr_addr[p]] = bus.wr_data[p];
          mpend[bus.wr_addr[p]] = 1'b0;
        end
      end
      if (bus.alloc_en && bus.alloc_addr != '0) mpend[bus.alloc_addr] = 1'b1;
    end

    step();
    idle();
    @(negedge clk);
    #1;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file with a built-in pending-write scoreboard. It is the successor to the single-write, two-read, negedge-written register file.
- Writes on posedge, with same-cycle write-to-read bypass, so the negedge trick is no longer needed.
- NWR write ports serve multi-issue writeback; NRD read ports serve decode.
- The per-register busy bit lets the hazard unit stall on outstanding producers.
- Sits between decode (reads, allocs) and writeback (writes).

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of 2, >= 2); register 0 hardwired to zero
NRD, 2, number of read ports (>= 1)
NWR, 2, number of write ports (>= 1)
AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NRD x AW  read addresses
rd_data  out  NRD x XLEN  read data, combinational
rd_busy  out  NRD  1 = addressed register has a pending (allocated, not yet written) producer
wr_en  in  NWR  write enables
wr_addr  in  NWR x AW  write addresses
wr_data  in  NWR x XLEN  write data
alloc_en  in  1  mark destination register pending (issue of a producer)
alloc_addr  in  AW  register to mark pending
busy_vec  out  NREGS  full pending bitmap, registered (bit 0 always 0)

Behaviour:
- Reset (rst_n=0, asynchronous): all registers := 0; all pending bits := 0.
  - While in reset, rd_data = 0 and rd_busy = 0 for every port; busy_vec = 0.
  - Writes and allocs are ignored.
- Release: first posedge with rst_n=1 performs normal updates.
- Register 0:
  - Reads return 0 and rd_busy = 0.
  - Writes and allocs to address 0 are dropped.
- Write:
  - At posedge, for each port p with wr_en[p] and wr_addr[p] != 0: reg[wr_addr[p]] := wr_data[p].
  - Write-write conflict (same address, several enabled ports): highest-index port wins; the others are discarded without error.
- Read (combinational, zero latency):
  - rd_data[r] = the winning same-cycle write to rd_addr[r] if one exists (bypass), else the stored value.
  - Bypass uses the same highest-index priority as the write.
- Pending bitmap:
  - At posedge, any enabled write to a nonzero register clears its pending bit.
  - alloc_en with alloc_addr != 0 sets the pending bit.
  - Alloc and write to the same register in the same cycle: alloc wins, bit ends at 1 (the new producer supersedes).
  - Alloc on an already-pending register: bit stays 1, no error.
- rd_busy[r]:
  - = pending[rd_addr[r]] AND NOT (a same-cycle enabled write to rd_addr[r]). A write arriving this cycle resolves the hazard, consistent with the bypass.
  - A same-cycle alloc does not affect rd_busy in that cycle; it is visible from the next cycle.
- Latency: write-to-stored 1 cycle; write-to-read 0 cycles (bypass); alloc-to-busy 1 cycle.
- Width rules:
  - Addresses are AW bits; no out-of-range check is needed since NREGS = 2^AW.
  - Data is passed unmodified; no sign handling.

Decomposition:
- Package regfile_pkg:
  - XLEN_DEF and NREGS_DEF constants
  - typedef reg_addr_t (logic [AW-1:0])
  - typedef xlen_t (logic [XLEN-1:0])
- Sub-module regfile_scoreboard:
  - Owns the NREGS-bit pending register and its alloc/clear priority.
  - Outputs busy_vec.
- regfile_mp instantiates regfile_scoreboard. It holds the storage array, the write-priority mux and the per-read-port bypass/busy logic (generate loops over NRD/NWR).

Test Plan:
- Reset: rst_n=0, read addresses 1..31 -> rd_data=0, rd_busy=0, busy_vec=0. Assert rst_n=0 mid-run after writes -> stored values and busy bits clear immediately, without waiting for a clock edge.
- Basic write/read: write x5=0xDEADBEEF on port 0 at edge N -> a read of 5 in the same cycle returns 0xDEADBEEF (bypass) and the value persists after the edge. A write to x0=0x1234 -> a read of 0 returns 0.
- Conflict: port0 writes x7=0x11 and port1 writes x7=0x22 in the same cycle -> same-cycle read and stored value are both 0x22.
- Scoreboard:
  - alloc x9 at edge N -> rd_busy=1 from cycle N+1.
  - write x9=0x55 in cycle M -> rd_busy=0 in cycle M with rd_data=0x55, busy_vec[9]=0 after the edge.
- Simultaneous alloc and write to x9 in one cycle -> rd_busy=0 during that cycle; busy_vec[9]=1 after the edge.
- Parameter sweep: NRD=4, NWR=3, XLEN=64, NREGS=64 -> the random-traffic scoreboard model matches for 10k cycles, including port-priority and x0 cases.
